// File: rtl/pipeline_if_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_if_pkg
// Shared widths, defaults and types for the instruction-fetch stage.
//   COMMON_WIDTH       : address / datapath width
//   INST_WIDTH         : instruction width
//   START_PC_DEFAULT   : PC loaded on reset
//   FIFO_DEPTH_DEFAULT : fetched-instruction buffer entries (also the
//                        maximum number of outstanding imem requests)
// -----------------------------------------------------------------------------
package pipeline_if_pkg;

  localparam int                      COMMON_WIDTH       = 32;
  localparam int                      INST_WIDTH         = 32;
  localparam logic [COMMON_WIDTH-1:0] START_PC_DEFAULT   = 32'h0000_0000;
  localparam int                      FIFO_DEPTH_DEFAULT = 2;

  // One buffered fetch result: the address it came from and the instruction.
  typedef struct packed {
    logic [COMMON_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0]   inst;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [COMMON_WIDTH-1:0] word_align(input logic [COMMON_WIDTH-1:0] addr);
    return {addr[COMMON_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pipeline_if_if.sv
// -----------------------------------------------------------------------------
// pipeline_if_if
// Bundles the fetch stage's pipeline-control, instruction-memory and IF/ID
// output signals.
//   master : the fetch unit (pipeline_if)
//   slave  : the surrounding core / memory / testbench
// Signals:
//   stall, redirect_valid, redirect_pc        : pipeline control into fetch
//   imem_req, imem_addr                       : fetch request out
//   imem_gnt, imem_rvalid, imem_rdata         : memory acceptance / response in
//   inst_valid, inst, inst_pc                 : instruction toward IF/ID
// -----------------------------------------------------------------------------
interface pipeline_if_if;
  import pipeline_if_pkg::*;

  logic                    stall;
  logic                    redirect_valid;
  logic [COMMON_WIDTH-1:0] redirect_pc;
  logic                    imem_req;
  logic [COMMON_WIDTH-1:0] imem_addr;
  logic                    imem_gnt;
  logic                    imem_rvalid;
  logic [INST_WIDTH-1:0]   imem_rdata;
  logic                    inst_valid;
  logic [INST_WIDTH-1:0]   inst;
  logic [COMMON_WIDTH-1:0] inst_pc;

  modport master (
    input  stall, redirect_valid, redirect_pc,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr,
    output inst_valid, inst, inst_pc
  );

  modport slave (
    output stall, redirect_valid, redirect_pc,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr,
    input  inst_valid, inst, inst_pc
  );

endinterface

// File: rtl/pipeline_if_inst_fifo.sv
// -----------------------------------------------------------------------------
// if_inst_fifo
// Small synchronous FIFO used both for fetched {pc,inst} entries and for the
// outstanding-request address queue.
//   clk, rst  : clock, asynchronous active-high reset
//   flush_i   : empty the FIFO (wins over push/pop)
//   push_i    : write data_i at the tail
//   pop_i     : drop the head entry
//   data_i    : write data
//   head_o    : head entry, all-zero when empty
//   count_o   : number of valid entries
// Push and pop in the same cycle both take effect, including when full.
// -----------------------------------------------------------------------------
module if_inst_fifo
  import pipeline_if_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int WIDTH = COMMON_WIDTH + INST_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W    = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == LAST_PTR) begin
      n = {PTR_W{1'b0}};
    end else begin
      n = p + PTR_W'(1'b1);
    end
    return n;
  endfunction

  assign do_pop_s  = pop_i & (count_q != {CNT_W{1'b0}});
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_push_s = push_i & ((count_q != FULL_CNT) | do_pop_s);

  // Next-state for pointers and occupancy; flush overrides everything.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so no stale data is ever observable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (!flush_i && do_push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o  = (count_q != {CNT_W{1'b0}}) ? mem_q[rd_ptr_q] : {WIDTH{1'b0}};
  assign count_o = count_q;

endmodule

// File: rtl/pipeline_if.sv
// -----------------------------------------------------------------------------
// pipeline_if
// Instruction-fetch stage. Issues word-aligned fetches to instruction memory
// under a credit rule, buffers returned instructions with their PCs and hands
// them to IF/ID. Redirects flush the buffer and drop in-flight responses.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : pipeline_if_if.master
//         in  : stall, redirect_valid, redirect_pc, imem_gnt, imem_rvalid,
//               imem_rdata
//         out : imem_req, imem_addr, inst_valid, inst, inst_pc
// Parameters:
//   START_PC   : fetch PC after reset
//   FIFO_DEPTH : instruction buffer entries = max outstanding requests
// -----------------------------------------------------------------------------
module pipeline_if
  import pipeline_if_pkg::*;
#(
  parameter logic [COMMON_WIDTH-1:0] START_PC   = START_PC_DEFAULT,
  parameter int                      FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  pipeline_if_if.master bus
);

  localparam int               CNT_W        = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]   CREDIT_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};

  logic [COMMON_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]        outstanding_q, outstanding_d;
  logic [CNT_W-1:0]        discard_q, discard_d;

  logic [CNT_W-1:0]        inst_count_s;
  logic [CNT_W-1:0]        aq_count_s;
  logic [COMMON_WIDTH-1:0] aq_head_s;
  fetch_entry_t            inst_head_s;
  fetch_entry_t            push_entry_s;
  logic [CNT_W:0]          credit_sum_s;
  logic                    req_s;
  logic                    fire_s;
  logic                    rsp_s;
  logic                    keep_s;
  logic                    inst_valid_s;
  logic                    pop_s;

  // Buffered instructions count against credit together with in-flight
  // requests, so a returning response always finds a free FIFO slot.
  assign credit_sum_s = {1'b0, outstanding_q} + {1'b0, inst_count_s};
  assign req_s        = ~rst & ~bus.redirect_valid & (credit_sum_s < CREDIT_LIMIT);
  assign fire_s       = req_s & bus.imem_gnt;

  // A response with no matching queued address is ignored so the counters
  // can never underflow.
  assign rsp_s        = bus.imem_rvalid & (aq_count_s != CNT_ZERO);
  assign keep_s       = rsp_s & ~bus.redirect_valid & (discard_q == CNT_ZERO);

  assign inst_valid_s = (inst_count_s != CNT_ZERO) & ~bus.redirect_valid;
  assign pop_s        = inst_valid_s & ~bus.stall;

  assign push_entry_s = '{pc: aq_head_s, inst: bus.imem_rdata};

  // Addresses of requests in flight, in issue order; popped by every response.
  if_inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (COMMON_WIDTH)
  ) u_addr_q (
    .clk     (clk),
    .rst     (rst),
    .flush_i (1'b0),
    .push_i  (fire_s),
    .pop_i   (rsp_s),
    .data_i  (word_align(pc_q)),
    .head_o  (aq_head_s),
    .count_o (aq_count_s)
  );

  // Fetched {pc, inst} entries waiting for IF/ID.
  if_inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (COMMON_WIDTH + INST_WIDTH)
  ) u_inst_q (
    .clk     (clk),
    .rst     (rst),
    .flush_i (bus.redirect_valid),
    .push_i  (keep_s),
    .pop_i   (pop_s),
    .data_i  (push_entry_s),
    .head_o  (inst_head_s),
    .count_o (inst_count_s)
  );

  // Next fetch PC and outstanding/discard accounting; redirect wins.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (bus.redirect_valid) begin
      // No request issues during a redirect, so every remaining in-flight
      // response (old discards included) belongs to the abandoned path.
      pc_d          = word_align(bus.redirect_pc);
      outstanding_d = outstanding_q - CNT_W'(rsp_s);
      discard_d     = outstanding_q - CNT_W'(rsp_s);
    end else begin
      if (fire_s) begin
        pc_d = pc_q + 32'd4;
      end else begin
        pc_d = pc_q;
      end
      outstanding_d = outstanding_q + CNT_W'(fire_s) - CNT_W'(rsp_s);
      if (rsp_s && (discard_q != CNT_ZERO)) begin
        discard_d = discard_q - CNT_W'(1'b1);
      end else begin
        discard_d = discard_q;
      end
    end
  end

  // Fetch PC and request counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= START_PC;
      outstanding_q <= CNT_ZERO;
      discard_q     <= CNT_ZERO;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  assign bus.imem_req   = req_s;
  assign bus.imem_addr  = word_align(pc_q);
  assign bus.inst_valid = inst_valid_s;
  assign bus.inst       = inst_head_s.inst;
  assign bus.inst_pc    = inst_head_s.pc;

endmodule

// File: tb/tb_pipeline_if.sv
// -----------------------------------------------------------------------------
// tb_pipeline_if
// Directed bench for pipeline_if: reset values, steady fetch, stall/credit,
// redirects (single, coincident with a response, back-to-back), grant
// back-pressure and PC wrap on a second instance started at 32'hFFFF_FFF8.
// Memory returns addr ^ 32'h5A5A_0F0F with a per-test fixed latency.
// -----------------------------------------------------------------------------
module tb_pipeline_if;
  import pipeline_if_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_vec   = 0;
  int   n_err   = 0;
  int   mem_lat = 1;
  int   cyc     = 0;

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } pend_t;
  pend_t pend_q[$];

  always #5 clk = ~clk;

  pipeline_if_if bus ();
  pipeline_if_if bus2 ();

  pipeline_if #(.START_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipeline_if #(.START_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // In-order memory for dut: a grant at edge k is seen by the DUT at edge k+mem_lat.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q.delete();
      bus.imem_rvalid <= 1'b0;
      bus.imem_rdata  <= 32'h0;
      cyc             <= 0;
    end else begin
      cyc <= cyc + 1;
      if (bus.imem_req && bus.imem_gnt)
        pend_q.push_back('{addr: bus.imem_addr, ready: cyc + mem_lat});
      if (pend_q.size() > 0 && pend_q[0].ready <= cyc + 1) begin
        bus.imem_rvalid <= 1'b1;
        bus.imem_rdata  <= mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        bus.imem_rvalid <= 1'b0;
        bus.imem_rdata  <= 32'h0;
      end
    end
  end

  // One-cycle memory for the wrap instance.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus2.imem_rvalid <= 1'b0;
      bus2.imem_rdata  <= 32'h0;
    end else begin
      bus2.imem_rvalid <= bus2.imem_req & bus2.imem_gnt;
      bus2.imem_rdata  <= mem_word(bus2.imem_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_inst(input string tag, input logic [31:0] pc);
    chk({tag, ".valid"}, {31'h0, bus.inst_valid}, 32'h1);
    chk({tag, ".pc"}, bus.inst_pc, pc);
    chk({tag, ".inst"}, bus.inst, mem_word(pc));
  endtask

  task automatic do_reset(input int lat);
    rst                = 1'b1;
    mem_lat            = lat;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_gnt       = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst                 = 1'b1;
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.imem_gnt        = 1'b1;
    bus2.stall          = 1'b0;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 32'h0;
    bus2.imem_gnt       = 1'b1;
    step();
    step();

    // Reset values
    chk("rst.req",      {31'h0, bus.imem_req},   32'h0);
    chk("rst.valid",    {31'h0, bus.inst_valid}, 32'h0);
    chk("rst.inst",     bus.inst,                32'h0);
    chk("rst.inst_pc",  bus.inst_pc,             32'h0);
    chk("rst.addr",     bus.imem_addr,           32'h0);
    chk("rst.req2",     {31'h0, bus2.imem_req},  32'h0);
    chk("rst.addr2",    bus2.imem_addr,          32'hFFFF_FFF8);

    // Steady fetch, 1-cycle memory; credit limits to 2 instructions per 3 cycles
    rst = 1'b0;
    #1;
    chk("e0.req",  {31'h0, bus.imem_req}, 32'h1);
    chk("e0.addr", bus.imem_addr,         32'h0);
    step(); #1;
    chk("e1.valid", {31'h0, bus.inst_valid}, 32'h0);
    chk("e1.addr",  bus.imem_addr,           32'h4);
    chk("e1.addr2", bus2.imem_addr,          32'hFFFF_FFFC);
    step(); #1;
    chk_inst("e2", 32'h0);
    chk("e2.req",  {31'h0, bus.imem_req}, 32'h0);
    chk("e2.pc2",  bus2.inst_pc,          32'hFFFF_FFF8);
    chk("e2.ins2", bus2.inst,             mem_word(32'hFFFF_FFF8));
    step(); #1;
    chk_inst("e3", 32'h4);
    chk("e3.req",   {31'h0, bus.imem_req}, 32'h1);
    chk("e3.addr",  bus.imem_addr,         32'h8);
    chk("e3.pc2",   bus2.inst_pc,          32'hFFFF_FFFC);
    chk("e3.addr2", bus2.imem_addr,        32'h0);
    step(); #1;
    chk("e4.valid", {31'h0, bus.inst_valid}, 32'h0);
    chk("e4.addr",  bus.imem_addr,           32'hC);
    step(); #1;
    chk_inst("e5", 32'h8);
    chk("e5.pc2", bus2.inst_pc, 32'h0);
    step(); #1;
    chk_inst("e6", 32'hC);
    step(); #1;
    chk("e7.valid", {31'h0, bus.inst_valid}, 32'h0);
    chk("e7.addr",  bus.imem_addr,           32'h14);

    // Stall for 5 cycles: buffer fills to 2, requests stop, nothing lost
    bus.stall = 1'b1;
    step(); #1;
    chk_inst("s8", 32'h10);
    chk("s8.req", {31'h0, bus.imem_req}, 32'h0);
    step(); #1;
    chk("s9.req", {31'h0, bus.imem_req}, 32'h0);
    chk("s9.pc",  bus.inst_pc,           32'h10);
    step(); step(); step(); #1;
    chk_inst("s12", 32'h10);
    chk("s12.req", {31'h0, bus.imem_req}, 32'h0);
    bus.stall = 1'b0;
    step(); #1;
    chk_inst("s13", 32'h14);
    chk("s13.addr", bus.imem_addr, 32'h18);
    step(); #1;
    chk("s14.valid", {31'h0, bus.inst_valid}, 32'h0);
    step(); #1;
    chk_inst("s15", 32'h18);
    step(); #1;
    chk_inst("s16", 32'h1C);

    // Grant withheld: request held, PC does not advance
    rst          = 1'b1;
    mem_lat      = 1;
    bus.imem_gnt = 1'b0;
    step(); step();
    rst = 1'b0;
    step(); #1;
    chk("g.req",  {31'h0, bus.imem_req}, 32'h1);
    chk("g.addr", bus.imem_addr,         32'h0);
    bus.imem_gnt = 1'b1;
    step(); #1;
    chk("g.addr1", bus.imem_addr, 32'h4);

    // Redirect to 0x103 with two responses in flight (3-cycle memory)
    do_reset(3);
    step(); #1;
    chk("r1.addr", bus.imem_addr, 32'h4);
    step(); #1;
    chk("r2.req", {31'h0, bus.imem_req}, 32'h0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    step();
    bus.redirect_valid = 1'b0;
    #1;
    chk("r3.addr", bus.imem_addr, 32'h100);
    step(); #1;
    chk("r4.req",   {31'h0, bus.imem_req},   32'h1);
    chk("r4.addr",  bus.imem_addr,           32'h100);
    chk("r4.valid", {31'h0, bus.inst_valid}, 32'h0);
    step(); #1;
    chk("r5.valid", {31'h0, bus.inst_valid}, 32'h0);
    chk("r5.addr",  bus.imem_addr,           32'h104);
    step(); step(); #1;
    chk("r7.valid", {31'h0, bus.inst_valid}, 32'h0);
    step(); #1;
    chk_inst("r8", 32'h100);
    step(); #1;
    chk_inst("r9", 32'h104);

    // Redirect coincident with a response while stalled, buffer non-empty
    do_reset(1);
    step(); step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0040;
    bus.stall          = 1'b1;
    #1;
    chk("c2.valid", {31'h0, bus.inst_valid}, 32'h0);
    chk("c2.req",   {31'h0, bus.imem_req},   32'h0);
    step();
    bus.redirect_valid = 1'b0;
    bus.stall          = 1'b0;
    #1;
    chk("c3.valid", {31'h0, bus.inst_valid}, 32'h0);
    chk("c3.req",   {31'h0, bus.imem_req},   32'h1);
    chk("c3.addr",  bus.imem_addr,           32'h40);
    step(); step(); #1;
    chk_inst("c5", 32'h40);

    // Back-to-back redirects: last target wins, discard count stays exact
    do_reset(3);
    step(); step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0080;
    step();
    bus.redirect_pc = 32'h0000_0200;
    #1;
    chk("b3.addr", bus.imem_addr, 32'h80);
    step();
    bus.redirect_valid = 1'b0;
    #1;
    chk("b4.req",  {31'h0, bus.imem_req}, 32'h1);
    chk("b4.addr", bus.imem_addr,         32'h200);
    step(); #1;
    chk("b5.addr", bus.imem_addr, 32'h204);
    step(); step(); #1;
    chk("b7.valid", {31'h0, bus.inst_valid}, 32'h0);
    step(); #1;
    chk_inst("b8", 32'h200);
    step(); #1;
    chk_inst("b9", 32'h204);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
